// File: rtl/register_file_bist.sv
// Built-in self-test initiator for the CPU register file: writes three
// deterministic patterns, reads them back on both ports and reports the result.
module register_file_bist #(
   parameter int NREGS  = 32,
   parameter int SEL_W  = 5,
   parameter int WORD_W = 32,
   parameter int ERR_W  = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   input  logic              abort,
   output logic              WEN,
   output logic [SEL_W-1:0]  wsel,
   output logic [WORD_W-1:0] wdat,
   output logic [SEL_W-1:0]  rsel1,
   output logic [SEL_W-1:0]  rsel2,
   input  logic [WORD_W-1:0] rdat1,
   input  logic [WORD_W-1:0] rdat2,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err_cnt,
   output logic [SEL_W-1:0]  first_err_sel,
   output logic [1:0]        first_err_pat
);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NREGS - 1);
   localparam int               SUM_W    = ERR_W + 1;
   localparam logic [ERR_W-1:0] ERR_MAX  = '1;

   state_t             state, state_nxt;
   logic [SEL_W-1:0]   idx, idx_nxt;
   logic [1:0]         pat, pat_nxt;
   logic [SEL_W-1:0]   idx2;
   logic               pass_q;
   logic               mis1, mis2;
   logic [SUM_W-1:0]   err_sum;
   logic [ERR_W-1:0]   err_sat;

   function automatic logic [WORD_W-1:0] pattern(input logic [1:0] p, input logic [SEL_W-1:0] i);
      logic [WORD_W-1:0] alt;
      alt = i[0] ? {(WORD_W/2){2'b01}} : {(WORD_W/2){2'b10}};
      case (p)
         2'd0:    return WORD_W'(i);
         2'd1:    return alt;
         default: return ~alt;
      endcase
   endfunction

   // Register 0 reads back as zero regardless of what was written.
   function automatic logic [WORD_W-1:0] expected(input logic [1:0] p, input logic [SEL_W-1:0] i);
      return (i == '0) ? '0 : pattern(p, i);
   endfunction

   assign idx2 = LAST_IDX - idx;

   // NOTE: every variable gets a default before the case, so no latches are inferred.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      pat_nxt   = pat;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_WRITE;
               idx_nxt   = '0;
               pat_nxt   = 2'd0;
            end
         end
         S_WRITE: begin
            if (idx == LAST_IDX) begin
               state_nxt = S_READ;
               idx_nxt   = '0;
            end else begin
               idx_nxt = idx + SEL_W'(1);
            end
         end
         S_READ: begin
            if (idx == LAST_IDX) begin
               idx_nxt = '0;
               if (pat == 2'd2) begin
                  state_nxt = S_DONE;
               end else begin
                  state_nxt = S_WRITE;
                  pat_nxt   = pat + 2'd1;
               end
            end else begin
               idx_nxt = idx + SEL_W'(1);
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      if (abort) begin
         state_nxt = S_IDLE;
         idx_nxt   = '0;
         pat_nxt   = 2'd0;
      end
   end

   // Outputs depend only on registered state; rdat feeds nothing but state.
   always_comb begin
      WEN   = 1'b0;
      wsel  = '0;
      wdat  = '0;
      rsel1 = '0;
      rsel2 = '0;
      busy  = (state == S_WRITE) || (state == S_READ);
      done  = (state == S_DONE);
      pass  = (state == S_DONE) ? (err_cnt == '0) : pass_q;
      if (state == S_WRITE) begin
         WEN  = 1'b1;
         wsel = idx;
         wdat = pattern(pat, idx);
      end
      if (state == S_READ) begin
         rsel1 = idx;
         rsel2 = idx2;
      end
   end

   assign mis1    = (state == S_READ) && (rdat1 != expected(pat, idx));
   assign mis2    = (state == S_READ) && (rdat2 != expected(pat, idx2));
   assign err_sum = {1'b0, err_cnt} + SUM_W'(mis1) + SUM_W'(mis2);
   assign err_sat = (err_sum > {1'b0, ERR_MAX}) ? ERR_MAX : err_sum[ERR_W-1:0];

   // NOTE: synchronous reset clears every flop; there is no storage array to leave unreset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state         <= S_IDLE;
         idx           <= '0;
         pat           <= 2'd0;
         pass_q        <= 1'b0;
         err_cnt       <= '0;
         first_err_sel <= '0;
         first_err_pat <= 2'd0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         state <= state_nxt;
         idx   <= idx_nxt;
         pat   <= pat_nxt;
         if (abort) begin
            pass_q <= 1'b0;
         end else if ((state == S_IDLE) && start) begin
            pass_q        <= 1'b0;
            err_cnt       <= '0;
            first_err_sel <= '0;
            first_err_pat <= 2'd0;
         end else if (state == S_DONE) begin
            pass_q <= (err_cnt == '0);
         end else if (mis1 || mis2) begin
            err_cnt <= err_sat;
            // The count never returns to zero inside a test, so zero marks "no error yet".
            if (err_cnt == '0) begin
               first_err_sel <= mis1 ? idx : idx2;
               first_err_pat <= pat;
            end
         end
      end
   end

endmodule

// File: tb/tb_register_file_bist.sv
// Scoreboarded bench for register_file_bist: a behavioural register file with
// injectable faults, a pattern-level reference model and a decoupled monitor.
module tb_register_file_bist;

   localparam int NREGS  = 32;
   localparam int SEL_W  = 5;
   localparam int WORD_W = 32;
   localparam int ERR_W  = 4;
   localparam int ERR_MX = (1 << ERR_W) - 1;
   localparam int RUN_CY = 6 * NREGS;

   logic              CLK = 1'b0;
   logic              RST, start, abort;
   logic              WEN;
   logic [SEL_W-1:0]  wsel, rsel1, rsel2, first_err_sel;
   logic [WORD_W-1:0] wdat, rdat1, rdat2, raw1, raw2;
   logic              busy, done, pass;
   logic [ERR_W-1:0]  err_cnt;
   logic [1:0]        first_err_pat;

   typedef struct {
      int err;
      int pass;
      int fsel;
      int fpat;
      int done_cyc;
   } exp_t;

   typedef struct {
      int          sel;
      logic [31:0] dat;
   } wr_t;

   exp_t sb_q[$];
   wr_t  wr_q[$];

   logic [WORD_W-1:0] mem [NREGS];
   int fmode = 0;   // 0 healthy, 1 stuck bit, 2 read ports stubbed to all ones
   int freg  = 0;
   int fbit  = 0;
   int fval  = 0;
   int cyc   = 0;
   int n_checks = 0;
   int n_fail   = 0;
   int start_cyc = 0;
   int busy_cnt  = 0;

   register_file_bist #(.NREGS(NREGS), .SEL_W(SEL_W), .WORD_W(WORD_W), .ERR_W(ERR_W)) dut (
      .CLK(CLK), .RST(RST), .start(start), .abort(abort),
      .WEN(WEN), .wsel(wsel), .wdat(wdat), .rsel1(rsel1), .rsel2(rsel2),
      .rdat1(rdat1), .rdat2(rdat2), .busy(busy), .done(done), .pass(pass),
      .err_cnt(err_cnt), .first_err_sel(first_err_sel), .first_err_pat(first_err_pat)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   function automatic logic [31:0] pat_val(input int p, input int i);
      logic [31:0] alt;
      alt = (i % 2 == 0) ? 32'hAAAAAAAA : 32'h55555555;
      if (p == 0) return 32'(i);
      if (p == 1) return alt;
      return ~alt;
   endfunction

   function automatic logic [31:0] fault_read(input int sel, input logic [31:0] raw,
                                              input int mode, input int r, input int b, input int v);
      logic [31:0] x;
      if (mode == 2) return '1;
      x = raw;
      if (mode == 1 && sel == r) x[b] = v[0];
      return x;
   endfunction

   // Behavioural register file: register 0 reads zero, reads are combinational.
   initial for (int i = 0; i < NREGS; i++) mem[i] = '0;
   always @(posedge CLK) if (WEN) mem[wsel] <= wdat;
   assign raw1  = (rsel1 == 0) ? '0 : mem[rsel1];
   assign raw2  = (rsel2 == 0) ? '0 : mem[rsel2];
   assign rdat1 = fault_read(int'(rsel1), raw1, fmode, freg, fbit, fval);
   assign rdat2 = fault_read(int'(rsel2), raw2, fmode, freg, fbit, fval);

   // Whole-test outcome from the pattern rules: each pass writes every register,
   // then every index compares port 1 (i) and port 2 (NREGS-1-i).
   function automatic exp_t model(input int mode, input int r, input int b, input int v);
      exp_t e;
      int   err  = 0;
      bit   seen = 0;
      e.fsel = 0;
      e.fpat = 0;
      for (int p = 0; p < 3; p++)
         for (int i = 0; i < NREGS; i++)
            for (int port = 0; port < 2; port++) begin
               int sel;
               logic [31:0] want, got;
               sel  = (port == 0) ? i : NREGS - 1 - i;
               want = (sel == 0) ? 32'h0 : pat_val(p, sel);
               got  = fault_read(sel, want, mode, r, b, v);
               if (got != want) begin
                  if (!seen) begin
                     seen   = 1;
                     e.fsel = sel;
                     e.fpat = p;
                  end
                  err = (err < ERR_MX) ? err + 1 : ERR_MX;
               end
            end
      e.err      = err;
      e.pass     = (err == 0);
      e.done_cyc = 0;
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops expected writes and test outcomes as the DUT presents them.
   always @(negedge CLK) begin
      if (WEN === 1'b1) begin
         check("write_pending", wr_q.size() != 0, 1);
         if (wr_q.size() != 0) begin
            wr_t w;
            w = wr_q.pop_front();
            check("wsel", 32'(wsel), 32'(w.sel));
            check("wdat", wdat, w.dat);
         end
      end
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
         check("done_expected", sb_q.size() != 0, 1);
         if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("done_cycle", cyc, e.done_cyc);
            check("busy_cycles", busy_cnt, RUN_CY);
            check("err_cnt", 32'(err_cnt), 32'(e.err));
            check("pass", 32'(pass), 32'(e.pass));
            check("first_err_sel", 32'(first_err_sel), 32'(e.fsel));
            check("first_err_pat", 32'(first_err_pat), 32'(e.fpat));
         end
         busy_cnt = 0;
      end else if (busy !== 1'b1) begin
         busy_cnt = 0;
      end
   end

   task automatic start_run();
      exp_t e;
      e = model(fmode, freg, fbit, fval);
      for (int p = 0; p < 3; p++)
         for (int i = 0; i < NREGS; i++) begin
            wr_t w;
            w.sel = i;
            w.dat = pat_val(p, i);
            wr_q.push_back(w);
         end
      @(negedge CLK);
      start = 1'b1;
      @(posedge CLK);
      #1;
      start     = 1'b0;
      start_cyc = cyc;
      e.done_cyc = start_cyc + RUN_CY;
      sb_q.push_back(e);
   endtask

   task automatic wait_done();
      for (int k = 0; k < 2 * RUN_CY; k++) begin
         if (sb_q.size() == 0) break;
         @(negedge CLK);
      end
      check("done_timeout", sb_q.size(), 0);
      @(negedge CLK);
   endtask

   task automatic to_negedge_at(input int c);
      do @(negedge CLK); while (cyc < c);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wen"}, 32'(WEN), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_pass"}, 32'(pass), 0);
      check({tag, "_err_cnt"}, 32'(err_cnt), 0);
      check({tag, "_first_err"}, {25'b0, first_err_pat, first_err_sel}, 0);
      check({tag, "_sels"}, {22'b0, wsel, rsel1}, 0);
      check({tag, "_wdat"}, wdat, 0);
   endtask

   initial begin
      RST   = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      check_all_zero("reset");

      // Healthy run; afterwards the file holds pattern 2 and pass stays high.
      start_run();
      wait_done();
      for (int i = 1; i < NREGS; i++) check("rf_final", mem[i], pat_val(2, i));
      check("pass_hold", 32'(pass), 1);

      // Register 5 bit 0 stuck low: pattern 0 and 1 fail on both ports.
      fmode = 1; freg = 5; fbit = 0; fval = 0;
      start_run();
      wait_done();
      check("stuck5_err_cnt", 32'(err_cnt), 4);
      check("stuck5_first_sel", 32'(first_err_sel), 5);
      check("stuck5_first_pat", 32'(first_err_pat), 0);
      check("stuck5_pass", 32'(pass), 0);

      // Abort mid-read: back to idle with no done pulse, then a full rerun.
      fmode = 0;
      start_run();
      to_negedge_at(start_cyc + 39);
      abort = 1'b1;
      @(posedge CLK);
      #1 abort = 1'b0;
      sb_q.delete();
      wr_q.delete();
      @(negedge CLK);
      check("abort_busy", 32'(busy), 0);
      check("abort_wen", 32'(WEN), 0);
      check("abort_pass", 32'(pass), 0);
      check("abort_err_cnt", 32'(err_cnt), 0);
      repeat (20) @(negedge CLK);
      check("abort_idle", 32'(busy), 0);
      start_run();
      wait_done();

      // A second start while busy is ignored; completion time is unchanged.
      start_run();
      to_negedge_at(start_cyc + 49);
      start = 1'b1;
      @(posedge CLK);
      #1 start = 1'b0;
      wait_done();

      // Reset mid-test after errors have accumulated clears everything.
      fmode = 1; freg = 3; fbit = 1; fval = 0;
      start_run();
      to_negedge_at(start_cyc + 99);
      check("pre_rst_err_seen", 32'(err_cnt != 0), 1);
      RST = 1'b1;
      @(posedge CLK);
      #1 RST = 1'b0;
      sb_q.delete();
      wr_q.delete();
      @(negedge CLK);
      check_all_zero("mid_rst");

      // Read ports stubbed to all ones: the error counter saturates.
      fmode = 2;
      start_run();
      wait_done();
      check("sat_err_cnt", 32'(err_cnt), ERR_MX);
      check("sat_first_sel", 32'(first_err_sel), 0);
      check("sat_pass", 32'(pass), 0);

      // Randomised stuck-bit faults against the reference model.
      for (int t = 0; t < 4; t++) begin
         fmode = 1;
         freg  = $urandom_range(NREGS - 1, 1);
         fbit  = $urandom_range(WORD_W - 1, 0);
         fval  = $urandom_range(1, 0);
         start_run();
         wait_done();
      end

      check("queues_drained", sb_q.size() + wr_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
